// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings and default sizing.
// Optional checksum support is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int DATA_W       = 32;
  localparam int ADDR_W_DEF   = 10;
  localparam int DEPTH_DEF    = 1024;
  localparam int HOLD_CYC_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// Host-to-loader stream, instruction-memory write port and processor control bundle.
// Checksum signals exist only when IMEM_LOADER_CHECKSUM_EN is defined.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              load_start;
  logic [ADDR_W:0]   load_count;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_reset_n;
  logic              busy;
  logic              done;
  logic              error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] expected_sum;
  logic [DATA_W-1:0] checksum;
`endif

  modport master (
    output load_start, load_count, in_valid, in_data,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output expected_sum,
    input  checksum,
`endif
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset_n, busy, done, error
  );

  modport slave (
    input  load_start, load_count, in_valid, in_data,
`ifdef IMEM_LOADER_CHECKSUM_EN
    input  expected_sum,
    output checksum,
`endif
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset_n, busy, done, error
  );

endinterface

// File: rtl/imem_loader_sum.sv
// Modulo-2^32 accumulator of accepted instruction words; used only with IMEM_LOADER_CHECKSUM_EN.
// Sum updates on the handshake edge, so it already includes a word in the cycle after acceptance.
module imem_loader_sum
  import imem_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_add_vld,
  input  logic [DATA_W-1:0] i_add_dat,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_sum <= '0;
    end else if (i_add_vld) begin
      r_sum <= r_sum + i_add_dat;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/imem_loader.sv
// Streams words into instruction memory and holds the processor in reset until HOLD_CYC cycles after the last write.
// Optional checksum verification before release is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  imem_loader_if.slave bus
);

  localparam int              HOLD_W  = $clog2(HOLD_CYC + 1);
  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_wcnt;
  logic [HOLD_W-1:0] r_hold;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_reset_n;
  logic              r_done;
  logic              r_error;

  logic w_can_start;
  logic w_cnt_ok;
  logic w_start_ok;
  logic w_start_bad;
  logic w_hs;
  logic w_last;
  logic w_hold_end;

  assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_cnt_ok    = (bus.load_count != '0) && (bus.load_count <= L_DEPTH);
  assign w_start_ok  = bus.load_start && w_can_start && w_cnt_ok;
  assign w_start_bad = bus.load_start && w_can_start && !w_cnt_ok;
  assign w_hs        = bus.in_valid && (r_state == ST_LOAD);
  assign w_last      = ({1'b0, r_wcnt} == (r_count - (ADDR_W + 1)'(1)));
  assign w_hold_end  = (r_hold == HOLD_W'(HOLD_CYC - 1));

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_exp_sum;
  logic [DATA_W-1:0] w_sum;

  imem_loader_sum u_sum (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_start_ok),
    .i_add_vld (w_hs),
    .i_add_dat (bus.in_data),
    .o_sum     (w_sum)
  );

  assign bus.checksum = w_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_exp_sum <= '0;
    end else if (w_start_ok) begin
      r_exp_sum <= bus.expected_sum;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_wcnt        <= '0;
      r_hold        <= '0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_cpu_reset_n <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RUN: begin
          // A reload from RUN drops the processor back into reset immediately.
          if (w_start_ok) begin
            r_count       <= bus.load_count;
            r_wcnt        <= '0;
            r_error       <= 1'b0;
            r_cpu_reset_n <= 1'b0;
            r_done        <= 1'b0;
            r_state       <= ST_LOAD;
          end else if (w_start_bad) begin
            r_error <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_hs) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_wcnt;
            r_mem_wdata <= bus.in_data;
            r_wcnt      <= r_wcnt + 1'b1;
            if (w_last) begin
              r_hold  <= '0;
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_hold_end) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_sum != r_exp_sum) begin
              r_error <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_cpu_reset_n <= 1'b1;
              r_done        <= 1'b1;
              r_state       <= ST_RUN;
            end
`else
            r_cpu_reset_n <= 1'b1;
            r_done        <= 1'b1;
            r_state       <= ST_RUN;
`endif
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == ST_LOAD);
  assign bus.busy        = (r_state == ST_LOAD) || (r_state == ST_HOLD);
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.cpu_reset_n = r_cpu_reset_n;
  assign bus.done        = r_done;
  assign bus.error       = r_error;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the processor's instruction-fetch path. Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory at consecutive word addresses.
- Holds the pipelined processor in reset while loading. Releases it only after the final write has landed plus a programmable guard interval.
- Sits between the bench or host link and the Top_Risc instruction memory write port. Replaces hardwired memory-init files.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- DEPTH, 1024, memory capacity in words (≤ 2^ADDR_W).
- HOLD_CYC, 4, cycles the processor stays in reset after the last write (must be ≥1).

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Load_Start  in  1  one-cycle request to begin a load.
- Load_Count  in  ADDR_W+1  number of words to load; sampled with Load_Start.
- In_Valid  in  1  In_Data valid.
- In_Data  in  32  instruction word.
- In_Ready  out  1  loader accepts a word this cycle.
- Mem_We  out  1  instruction-memory write enable.
- Mem_Addr  out  ADDR_W  word address.
- Mem_Wdata  out  32  write data.
- Cpu_Reset_  out  1  active-low reset to the processor.
- Busy  out  1  state is LOAD or HOLD.
- Done  out  1  load complete, processor running.
- Error  out  1  sticky bad-request flag.

Behaviour:
- States: IDLE, LOAD, HOLD, RUN. All outputs are registered except In_Ready and Busy, which decode the state register.
- Reset (any state, including mid-load):
  - Next state is IDLE.
  - Cpu_Reset_=0, Mem_We=0, Mem_Addr=0, Mem_Wdata=0, Done=0, Error=0.
  - Word counter and hold counter are cleared.
  - Memory contents already written are left untouched.
- IDLE:
  - In_Ready=0; processor held in reset.
  - Load_Start with 1 ≤ Load_Count ≤ DEPTH: latch the count, clear the address counter and Error, go to LOAD.
  - Load_Start with Load_Count=0 or Load_Count>DEPTH: set Error=1 and stay in IDLE.
- LOAD:
  - In_Ready=1.
  - Handshake occurs when In_Valid && In_Ready. In the following cycle: Mem_We=1, Mem_Addr=current counter, Mem_Wdata=In_Data. Write latency is exactly 1 cycle.
  - The counter increments per handshake. In_Valid without In_Ready does nothing.
  - Handshake on word Load_Count-1 → go to HOLD. In_Ready is 0 in the next cycle.
  - Back-to-back handshakes produce back-to-back writes with no bubbles.
- HOLD:
  - In_Ready=0; Cpu_Reset_ stays 0.
  - The last write lands in the first HOLD cycle.
  - The hold counter runs HOLD_CYC cycles, then the state goes to RUN.
- RUN:
  - Cpu_Reset_=1 and Done=1, both registered on entry.
  - Load_Start with a valid count: next cycle Cpu_Reset_=0, Done=0, state LOAD (reload).
  - Load_Start with an invalid count: Error=1, processor keeps running.
- Load_Start in LOAD or HOLD is ignored. Error is cleared only by Reset or by a valid Load_Start.
- Address never wraps: the count is bounded by DEPTH, so the maximum address is DEPTH-1.
- Mem_We is never asserted outside the cycle after a handshake.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro:
  - Adds input Expected_Sum[31:0], sampled with Load_Start, and output Checksum[31:0].
  - Checksum is the modulo-2^32 sum of accepted words, cleared on load start.
  - On leaving HOLD: if Checksum ≠ Expected_Sum, set Error=1, go to IDLE, and keep Cpu_Reset_=0. Otherwise go to RUN.
- Without the macro: both ports are absent and HOLD always goes to RUN.

Decomposition:
- Package imem_loader_pkg holds:
  - the state encodings (IDLE=0, LOAD=1, HOLD=2, RUN=3);
  - default ADDR_W, DEPTH and HOLD_CYC;
  - the data width constant 32.
- One natural sub-module: imem_loader_sum, the checksum accumulator. It is instantiated only under IMEM_LOADER_CHECKSUM_EN.

Test Plan:
- Basic load: Load_Start, Load_Count=3; words 0x20080005, 0x20090007, 0x01095020 with In_Valid held → writes at addr 0,1,2 in 3 consecutive cycles, each one cycle after its handshake. Cpu_Reset_ rises and Done=1 HOLD_CYC cycles after the first HOLD cycle.
- Backpressure/gaps: In_Valid toggling 1,0,0,1,1 with Load_Count=3 → exactly 3 writes, addresses contiguous, no writes in gap cycles.
- Bad count: Load_Count=0, then Load_Count=DEPTH+1 → Error=1, state IDLE, In_Ready=0, Cpu_Reset_=0. A following valid Load_Start clears Error.
- Reset mid-load: assert Reset after 2 of 5 words → next cycle IDLE, Mem_We=0, Cpu_Reset_=0, Done=0. Words 0–1 remain in memory.
- Reload from RUN: Load_Start with Load_Count=1 while Done=1 → next cycle Cpu_Reset_=0, Done=0, In_Ready=1. The new word is written at addr 0.
- Checksum (macro on): Expected_Sum=0x0000000A, words 3 and 7 → RUN. Expected_Sum=0x0000000B → Error=1, IDLE, Cpu_Reset_ stays 0.
